// File: rtl/dual_issue_packer_if.sv
// Handshake/packet bundle between the instruction stream, dual_issue_packer and the decode path.
interface dual_issue_packer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          mode;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instrA;
    logic [31:0]   out_instrB;
    logic          out_validA;
    logic          out_validB;
    logic [6:0]    opcodeA;
    logic [6:0]    opcodeB;
    logic [2:0]    funct3A;
    logic [2:0]    funct3B;
    logic [6:0]    funct7A;
    logic [6:0]    funct7B;
    logic [CW-1:0] count;

    modport master (
        output mode, flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instrA, out_instrB, out_validA, out_validB,
        input  opcodeA, opcodeB, funct3A, funct3B, funct7A, funct7B, count
    );

    modport slave (
        input  mode, flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instrA, out_instrB, out_validA, out_validB,
        output opcodeA, opcodeB, funct3A, funct3B, funct7A, funct7B, count
    );
endinterface

// File: rtl/dual_issue_packer.sv
// FIFO-buffered RV32I issue stage emitting one- or two-lane packets with registered decode fields.
// Optional macro ISSUE_HAZARD_CHECK_EN: enables RAW / control-flow pairing checks in split mode.
module dual_issue_packer #(
    parameter int DEPTH    = 4,
    parameter int WAIT_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    dual_issue_packer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    state_t        state_r;
    state_t        state_s;
    logic [WW-1:0] wait_cnt_r;
    logic [WW-1:0] wait_cnt_s;

    logic [31:0]   head_s;
    logic [31:0]   next_s;
    logic [31:0]   lane_b_s;
    logic          push_s;
    logic          slot_free_s;
    logic          issue_s;
    logic          pair_s;
    logic          hazard_s;
    logic [1:0]    pop_s;

    logic          out_valid_r;
    logic          out_valid_a_r;
    logic          out_valid_b_r;
    logic [31:0]   out_instr_a_r;
    logic [31:0]   out_instr_b_r;
    logic [6:0]    opcode_a_r;
    logic [6:0]    opcode_b_r;
    logic [2:0]    funct3_a_r;
    logic [2:0]    funct3_b_r;
    logic [6:0]    funct7_a_r;
    logic [6:0]    funct7_b_r;

`ifdef ISSUE_HAZARD_CHECK_EN
    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
            7'b1101111, 7'b0110111, 7'b0010111: writes_rd = 1'b1;
            default:                            writes_rd = 1'b0;
        endcase
    endfunction

    // B depends on A when it reads A's destination register, or A may redirect the stream.
    function automatic logic pair_hazard(input logic [31:0] a, input logic [31:0] b);
        logic rs1_used;
        logic rs2_used;
        logic raw;
        logic ctrl;
        rs1_used = !(b[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
        rs2_used = b[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
        raw      = writes_rd(a[6:0]) && (a[11:7] != 5'd0) &&
                   ((rs1_used && (b[19:15] == a[11:7])) || (rs2_used && (b[24:20] == a[11:7])));
        ctrl     = a[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
        return raw || ctrl;
    endfunction
`endif

    // Head-of-FIFO candidates and the pairing hazard between them.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        next_s = mem_r[rd_ptr_r + AW'(1)];
`ifdef ISSUE_HAZARD_CHECK_EN
        hazard_s = pair_hazard(head_s, next_s);
`else
        hazard_s = 1'b0;
`endif
    end

    assign slot_free_s = !out_valid_r || bus.out_ready;
    assign push_s      = bus.in_valid && (count_r < CW'(DEPTH)) && !bus.flush;

    // Issue decision and wait-state next-state logic.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        issue_s    = 1'b0;
        pair_s     = 1'b0;
        if (bus.flush) begin
            state_s    = ST_IDLE;
            wait_cnt_s = {WW{1'b0}};
        end else if (!slot_free_s) begin
            if (bus.mode || (count_r == {CW{1'b0}})) begin
                state_s    = ST_IDLE;
                wait_cnt_s = {WW{1'b0}};
            end else begin
                state_s    = state_r;
                wait_cnt_s = wait_cnt_r;
            end
        end else if (bus.mode) begin
            issue_s    = (count_r != {CW{1'b0}});
            state_s    = ST_IDLE;
            wait_cnt_s = {WW{1'b0}};
        end else if (count_r >= CW'(2)) begin
            issue_s    = 1'b1;
            pair_s     = !hazard_s;
            state_s    = ST_IDLE;
            wait_cnt_s = {WW{1'b0}};
        end else if (count_r == CW'(1)) begin
            if (wait_cnt_r == WW'(WAIT_MAX)) begin
                issue_s    = 1'b1;
                state_s    = ST_IDLE;
                wait_cnt_s = {WW{1'b0}};
            end else begin
                state_s    = ST_WAIT;
                wait_cnt_s = wait_cnt_r + WW'(1);
            end
        end else begin
            state_s    = ST_IDLE;
            wait_cnt_s = {WW{1'b0}};
        end
    end

    // Pop size and the instruction presented on lane B.
    always_comb begin
        if (issue_s) begin
            pop_s = pair_s ? 2'd2 : 2'd1;
        end else begin
            pop_s = 2'd0;
        end
        lane_b_s = pair_s ? next_s : NOP;
    end

    // Wait-state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {WW{1'b0}};
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // FIFO storage; contents are don't-care until the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_instr;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (bus.flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(push_s);
            rd_ptr_r <= rd_ptr_r + AW'(pop_s);
            count_r  <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Output packet register; loads only when the slot is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush) begin
            out_valid_r   <= 1'b0;
            out_valid_a_r <= 1'b0;
            out_valid_b_r <= 1'b0;
            out_instr_a_r <= NOP;
            out_instr_b_r <= NOP;
            opcode_a_r    <= NOP[6:0];
            opcode_b_r    <= NOP[6:0];
            funct3_a_r    <= NOP[14:12];
            funct3_b_r    <= NOP[14:12];
            funct7_a_r    <= NOP[31:25];
            funct7_b_r    <= NOP[31:25];
        end else if (slot_free_s) begin
            if (issue_s) begin
                out_valid_r   <= 1'b1;
                out_valid_a_r <= 1'b1;
                out_valid_b_r <= pair_s;
                out_instr_a_r <= head_s;
                out_instr_b_r <= lane_b_s;
                opcode_a_r    <= head_s[6:0];
                opcode_b_r    <= lane_b_s[6:0];
                funct3_a_r    <= head_s[14:12];
                funct3_b_r    <= lane_b_s[14:12];
                funct7_a_r    <= head_s[31:25];
                funct7_b_r    <= lane_b_s[31:25];
            end else begin
                out_valid_r   <= 1'b0;
                out_valid_a_r <= 1'b0;
                out_valid_b_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = (count_r < CW'(DEPTH));
    assign bus.count      = count_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_validA = out_valid_a_r;
    assign bus.out_validB = out_valid_b_r;
    assign bus.out_instrA = out_instr_a_r;
    assign bus.out_instrB = out_instr_b_r;
    assign bus.opcodeA    = opcode_a_r;
    assign bus.opcodeB    = opcode_b_r;
    assign bus.funct3A    = funct3_a_r;
    assign bus.funct3B    = funct3_b_r;
    assign bus.funct7A    = funct7_a_r;
    assign bus.funct7B    = funct7_b_r;
endmodule

// File: tb/tb_dual_issue_packer.sv
// Self-checking bench for dual_issue_packer: pairing table, hand-written corner sequences, random vs model.
module tb_dual_issue_packer;
    localparam int DEPTH    = 4;
    localparam int WAIT_MAX = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_issue_packer_if #(.DEPTH(DEPTH)) bus();
    dual_issue_packer #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        hz;
    } pair_vec_t;
    pair_vec_t vecs [8];

    // Reference model state: FIFO contents, packet, lone-wait cycles.
    logic [31:0] mq [$];
    logic        m_v;
    logic        m_vb;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic md, input logic fl, input logic iv, input logic [31:0] ii,
                         input logic ordy);
        bus.mode      = md;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_instr  = ii;
        bus.out_ready = ordy;
    endtask

`ifdef ISSUE_HAZARD_CHECK_EN
    function automatic bit m_hazard(input logic [31:0] a, input logic [31:0] b);
        bit a_writes = (a[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                        7'b1101111, 7'b0110111, 7'b0010111}) && (a[11:7] != 5'd0);
        bit b_rs1    = !(b[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
        bit b_rs2    = b[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
        bit ctrl     = a[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
        return ctrl || (a_writes && ((b_rs1 && b[19:15] == a[11:7]) || (b_rs2 && b[24:20] == a[11:7])));
    endfunction
`endif

    task automatic model_step(input logic md, input logic fl, input logic iv, input logic [31:0] ii,
                              input logic ordy);
        bit acc;
        bit iss;
        bit pr;
        acc = iv && (mq.size() < DEPTH);
        if (fl) begin
            mq.delete();
            m_v    = 1'b0;
            m_wait = 0;
            return;
        end
        iss = 1'b0;
        pr  = 1'b0;
        if (!m_v || ordy) begin
            if (md) begin
                iss    = (mq.size() >= 1);
                m_wait = 0;
            end else if (mq.size() >= 2) begin
                iss = 1'b1;
`ifdef ISSUE_HAZARD_CHECK_EN
                pr  = !m_hazard(mq[0], mq[1]);
`else
                pr  = 1'b1;
`endif
                m_wait = 0;
            end else if (mq.size() == 1) begin
                if (m_wait == WAIT_MAX) begin
                    iss    = 1'b1;
                    m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
            end
            if (iss) begin
                m_v  = 1'b1;
                m_a  = mq.pop_front();
                m_vb = pr;
                m_b  = pr ? mq.pop_front() : NOP;
            end else begin
                m_v = 1'b0;
            end
        end else if (md || mq.size() == 0) begin
            m_wait = 0;
        end
        if (acc) mq.push_back(ii);
    endtask

    task automatic compare_model();
        check("rnd out_valid", 32'(bus.out_valid), 32'(m_v));
        check("rnd count", 32'(bus.count), 32'(mq.size()));
        check("rnd in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        if (m_v) begin
            check("rnd validA", 32'(bus.out_validA), 32'd1);
            check("rnd validB", 32'(bus.out_validB), 32'(m_vb));
            check("rnd instrA", bus.out_instrA, m_a);
            check("rnd instrB", bus.out_instrB, m_b);
            check("rnd opcodeA", 32'(bus.opcodeA), 32'(m_a[6:0]));
            check("rnd funct3A", 32'(bus.funct3A), 32'(m_a[14:12]));
            check("rnd funct7A", 32'(bus.funct7A), 32'(m_a[31:25]));
            check("rnd opcodeB", 32'(bus.opcodeB), 32'(m_b[6:0]));
            check("rnd funct3B", 32'(bus.funct3B), 32'(m_b[14:12]));
            check("rnd funct7B", 32'(bus.funct7B), 32'(m_b[31:25]));
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0] op;
        case ($urandom_range(0, 8))
            0:       op = 7'b0110011;
            1:       op = 7'b0010011;
            2:       op = 7'b0000011;
            3:       op = 7'b0100011;
            4:       op = 7'b1100011;
            5:       op = 7'b1101111;
            6:       op = 7'b0110111;
            7:       op = 7'b0010111;
            default: op = 7'b1100111;
        endcase
        return {($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        exp_pair;
        logic        md;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] ii;

        vecs[0] = '{32'h005201B3, 32'h40838333, 1'b0};  // add / sub, independent
        vecs[1] = '{32'h00500093, 32'h00108133, 1'b1};  // addi x1 -> add reads x1
        vecs[2] = '{32'h00000063, 32'h005201B3, 1'b1};  // beq leads
        vecs[3] = '{32'h00500093, 32'h000080B7, 1'b0};  // lui ignores its rs1 field
        vecs[4] = '{32'h00000013, 32'h00000033, 1'b0};  // rd = x0 never conflicts
        vecs[5] = '{32'h0000A083, 32'h00112023, 1'b1};  // lw x1 -> sw reads x1 on rs2
        vecs[6] = '{32'h005201B3, 32'h00300063, 1'b1};  // add x3 -> beq reads x3 on rs2
        vecs[7] = '{32'h00112223, 32'h004202B3, 1'b0};  // store writes nothing

        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset instrA", bus.out_instrA, NOP);
        check("reset instrB", bus.out_instrB, NOP);
        check("reset opcodeA", 32'(bus.opcodeA), 32'h13);
        check("reset funct7A", 32'(bus.funct7A), 32'd0);
        check("reset count", 32'(bus.count), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);

        // Unified: two packets on consecutive cycles.
        drive(1'b1, 1'b0, 1'b1, 32'h00500093, 1'b1);
        tick();
        check("uni first count", 32'(bus.count), 32'd1);
        check("uni no bypass", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h005201B3, 1'b1);
        tick();
        check("uni p1 valid", 32'(bus.out_valid), 32'd1);
        check("uni p1 validB", 32'(bus.out_validB), 32'd0);
        check("uni p1 instrA", bus.out_instrA, 32'h00500093);
        check("uni p1 opcodeA", 32'(bus.opcodeA), 32'h13);
        check("uni p1 instrB", bus.out_instrB, NOP);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("uni p2 valid", 32'(bus.out_valid), 32'd1);
        check("uni p2 validA", 32'(bus.out_validA), 32'd1);
        check("uni p2 instrA", bus.out_instrA, 32'h005201B3);
        check("uni p2 opcodeA", 32'(bus.opcodeA), 32'h33);
        check("uni p2 count", 32'(bus.count), 32'd0);
        tick();
        check("uni drained", 32'(bus.out_valid), 32'd0);

        // Split pairing decisions, packet held with out_ready low.
        for (int i = 0; i < 8; i++) begin
`ifdef ISSUE_HAZARD_CHECK_EN
            exp_pair = !vecs[i].hz;
`else
            exp_pair = 1'b1;
`endif
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            tick();
            drive(1'b0, 1'b0, 1'b1, vecs[i].a, 1'b0);
            tick();
            drive(1'b0, 1'b0, 1'b1, vecs[i].b, 1'b0);
            tick();
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
            check("pair valid", 32'(bus.out_valid), 32'd1);
            check("pair validB", 32'(bus.out_validB), 32'(exp_pair));
            check("pair instrA", bus.out_instrA, vecs[i].a);
            check("pair instrB", bus.out_instrB, exp_pair ? vecs[i].b : NOP);
            check("pair funct7B", 32'(bus.funct7B), exp_pair ? 32'(vecs[i].b[31:25]) : 32'd0);
            check("pair count", 32'(bus.count), exp_pair ? 32'd0 : 32'd1);
        end

        // Lone split instruction issues WAIT_MAX+1 cycles after it becomes visible.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h00108133, 1'b1);
        tick();
        for (int j = 0; j <= WAIT_MAX; j++) begin
            check("lone waiting", 32'(bus.out_valid), 32'd0);
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            tick();
        end
        check("lone issued", 32'(bus.out_valid), 32'd1);
        check("lone validB", 32'(bus.out_validB), 32'd0);
        check("lone instrA", bus.out_instrA, 32'h00108133);
        check("lone count", 32'(bus.count), 32'd0);

        // Partner arriving inside the wait window forms a pair.
        drive(1'b0, 1'b0, 1'b1, 32'h005201B3, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h40838333, 1'b1);
        tick();
        check("partner not yet", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("partner validB", 32'(bus.out_validB), 32'd1);
        check("partner instrB", bus.out_instrB, 32'h40838333);

        // Backpressure fills FIFO, then flush.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h00000093 + (i << 20), 1'b0);
            tick();
        end
        check("full count", 32'(bus.count), 32'd4);
        check("full in_ready", 32'(bus.in_ready), 32'd0);
        check("full held instrA", bus.out_instrA, 32'h00000093);
        drive(1'b1, 1'b0, 1'b1, 32'h00600093, 1'b1);
        tick();
        check("full pop instrA", bus.out_instrA, 32'h00100093);
        check("full pop count", 32'(bus.count), 32'd3);
        drive(1'b1, 1'b1, 1'b1, 32'h00700093, 1'b0);
        tick();
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        check("flush count", 32'(bus.count), 32'd0);
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("flush dropped input", 32'(bus.count), 32'd0);

        // Random traffic against the reference model.
        md = 1'b0;
        drive(md, 1'b1, 1'b0, 32'h0, 1'b0);
        model_step(md, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) md = ~md;
            fl   = ($urandom_range(0, 99) < 2);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            ii   = gen_instr();
            drive(md, fl, iv, ii, ordy);
            model_step(md, fl, iv, ii, ordy);
            tick();
            compare_model();
        end

        // Asynchronous reset mid-operation.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h00500093, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("async rst count", 32'(bus.count), 32'd0);
        check("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async rst instrA", bus.out_instrA, NOP);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post rst in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dual_issue_packer.md
# dual_issue_packer

Instruction issue buffer feeding the two-lane decode path. Accepts a single in-order stream of 32-bit RV32I instructions, buffers them in a FIFO and emits an issue packet with lane A / lane B instructions and pre-extracted opcode/funct3/funct7 fields for the control unit. In unified mode (`mode=1`) it issues one instruction per packet. In split mode (`mode=0`) it pairs two consecutive independent instructions, with a bounded wait for a partner.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `WAIT_MAX`, 3: cycles a lone split-mode instruction waits for a partner before issuing alone; ≥0.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mode` in 1: 1 = unified, 0 = split.
- `flush` in 1: synchronous clear of FIFO, output packet and wait counter.
- `in_valid` in 1 / `in_ready` out 1 / `in_instr` in 32: input handshake and instruction.
- `out_valid` out 1 / `out_ready` in 1: packet handshake.
- `out_instrA`, `out_instrB` out 32: lane instructions. Lane A is older.
- `out_validA`, `out_validB` out 1: per-lane valid bits, qualified by `out_valid`.
- `opcodeA/B` out 7, `funct3A/B` out 3, `funct7A/B` out 7: fields of the lane instructions.
- `count` out clog2(DEPTH+1): FIFO occupancy, excludes the output packet.

## Operation
- Field slices: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25]. Fields are registered with the packet, never combinational from the FIFO.
- `in_ready = (count < DEPTH)`. A push and a pop in the same cycle are legal when the FIFO is not full. The pointer wrap is modulo DEPTH.
- Slot free condition: `out_valid==0 || out_ready==1`. The issue decision is evaluated only when the slot is free; otherwise the packet holds stable.
- Unified mode: `count≥1` issues the head as a single packet.
- Split mode, `count≥2`: head goes to lane A, head+1 to lane B. Issue a pair unless one of these conditions holds, in which case issue A single:
  - A writes rd≠0, where A's opcode ∈ {0110011, 0010011, 0000011, 1100111, 1101111, 0110111, 0010111}, and B reads that register. B reads rs1 unless its opcode ∈ {0110111, 0010111, 1101111}. B reads rs2 if its opcode ∈ {0110011, 0100011, 1100011}.
  - A is control flow (1100011, 1101111, 1100111).
- Split mode, `count==1`:
  - If `wait_cnt==WAIT_MAX`, issue single.
  - Otherwise increment `wait_cnt` (state WAIT).
- FSM states:
  - IDLE (no issue candidate) → WAIT when a lone candidate exists in split mode.
  - WAIT → IDLE on any issue.
  - WAIT → IDLE on a mode change, flush, or `count==0`.
  - `wait_cnt` clears on leaving WAIT.
- Single packet: `out_validB=0`, `out_instrB=0x00000013` (NOP), with B fields taken from the NOP. Pops are 1 or 2 entries.
- Flush: FIFO empties, `out_valid=0`, FSM goes to IDLE. An input presented in the flush cycle is dropped. Flush has priority over push and issue.
- Reset values:
  - `out_valid`, `out_validA`, `out_validB` = 0.
  - `out_instrA/B` = 0x00000013.
  - `opcodeA/B` = 0010011, `funct3A/B` = 000, `funct7A/B` = 0000000.
  - `count` = 0, so `in_ready` = 1.
  - FSM = IDLE.
- Reset asserted mid-operation discards all buffered instructions immediately.

## Timing
- An instruction accepted at edge k is visible in `count` after edge k. The earliest packet is registered at edge k+1, so `out_valid` is high in cycle k+1 (unified, empty pipe). There is no input→output bypass.
- Split lone instruction: the packet appears WAIT_MAX+1 cycles after the FIFO-visible cycle, unless a partner arrives first.
- Sustained throughput: 1 packet per cycle with `out_ready=1`; up to 2 instructions per cycle in split mode. Input is limited to 1 instruction per cycle.
- `out_*` is stable while `out_valid && !out_ready`.

## Configuration
- `ISSUE_HAZARD_CHECK_EN` defined: RAW and control-flow checks apply as above.
- `ISSUE_HAZARD_CHECK_EN` undefined: split mode pairs any two head entries unconditionally. The software scheduler guarantees independence. WAIT behaviour is unchanged.

## Test plan
- Reset then release → `out_valid=0`, `out_instrA=0x00000013`, `opcodeA=0010011`, `count=0`, `in_ready=1`.
- Unified, push 0x00500093 then 0x005201B3, `out_ready=1` → two packets on consecutive cycles, each `out_validA=1`, `out_validB=0`; `opcodeA` = 0010011 then 0110011.
- Split, push 0x005201B3 and 0x40838333 back-to-back → one packet with `out_validA=out_validB=1` and `funct7B=0100000`.
- Split, push 0x00500093 and 0x00108133 (RAW on x1) → packet 1 is A-only 0x00500093. Then 0x00108133 waits WAIT_MAX=3 cycles and issues A-only. Without `ISSUE_HAZARD_CHECK_EN` → one pair.
- Split, push 0x00000063 (beq) and 0x005201B3 → beq issues single, then add issues after the timeout.
- Unified, DEPTH=4, `out_ready=0`, push 6 → 5 accepted (4 in FIFO plus 1 in the packet), `in_ready=0`, `count=4`. Assert `flush` → next cycle `out_valid=0`, `count=0`, `in_ready=1`.
